tdc_gpx2_frame_rx: RTL and testbench
====================================

// Module: tdc_gpx2_frame_rx
// PURPOSE
//  Receiver for the GPX2 TDC serial result interface (two TDCs x 4 lanes = 8 Frame/Sdo pairs).
//  Each lane deserialises 24-bit MSB-first words and checks the frame pattern 0xFF0000.
//  Completed words are arbitrated round-robin onto one valid/ready stream for the echo/packet logic.
//  Shares the 200 MHz clock that is forwarded to the TDC as its reference clock.
// PARAMETERS
//  NUM_CH    8   number of Frame/Sdo lane pairs
//  CH_W      3   channel-index width; 2**CH_W >= NUM_CH
//  DATA_W    24  bits per result word
//  FRAME_HI  8   leading Frame-high bits per word; remaining DATA_W-FRAME_HI bits are Frame-low
// PORTS
//  CpSl_Clk200M_i   in   1           200 MHz clock; all logic on posedge
//  CpSl_Rst_i       in   1           synchronous reset, active high
//  CpSv_Frame_i     in   NUM_CH      TDC Frame lines; bit n = lane n
//  CpSv_Sdo_i       in   NUM_CH      TDC serial data lines; bit n = lane n
//  CpSl_TdcVld_o    out  1           output word valid
//  CpSl_TdcRdy_i    in   1           consumer ready
//  CpSv_TdcData_o   out  DATA_W      received word
//  CpSv_TdcCh_o     out  CH_W        source lane of CpSv_TdcData_o
//  CpSv_Ovf_o       out  NUM_CH      sticky per-lane overflow flag
//  CpSl_OvfClr_i    in   1           one-cycle pulse; clears all CpSv_Ovf_o bits
//  CpSl_FrmErr_o    out  1           one-cycle pulse on any lane frame error
//  CpSv_FrmErrCnt_o out  16          saturating frame-error count, all lanes
// BEHAVIOUR
//  Reset: all outputs 0. Lane shift registers, counters and hold registers are cleared.
//   Round-robin pointer = 0. The registered Frame-previous bits reset to 1, so a Frame
//   already high when reset is released is not taken as a word start.
//   Reset mid-word discards the partial word and produces no output or error.
//  Input stage: Frame and Sdo are registered once. Lane logic works on the registered copies.
//  Lane FSM states:
//   IDLE: a start is registered Frame 1 with previous registered Frame 0. On a start,
//    take Sdo as bit DATA_W-1, set cnt=1 and move to SHIFT.
//   SHIFT: each cycle shift Sdo in MSB-first and increment cnt.
//    Expected Frame = (cnt < FRAME_HI).
//    Frame mismatch: drop the word, pulse CpSl_FrmErr_o, increment the error count
//    (saturates at 0xFFFF), return to IDLE.
//    When cnt == DATA_W-1 and Frame is correct: load the word into the lane hold
//    register, set hold_vld and return to IDLE.
//   A new start on the very next cycle after the last bit is accepted with no gap.
//   Lanes whose Frame stays low emit nothing.
//  Overflow: a word completes while hold_vld is still set -> the new word is dropped,
//   the old word is kept and Ovf[n] is set. Ovf[n] stays set until CpSl_OvfClr_i.
//   Set and clear in the same cycle -> set wins.
//  Arbiter: runs when the output register is empty, or is being emptied this cycle
//   (Vld & Rdy). It grants the first lane with hold_vld at or after the pointer, wrapping.
//   The grant loads CpSv_TdcData_o / CpSv_TdcCh_o, clears that lane's hold_vld and sets
//   the pointer to grant+1 mod NUM_CH.
//   A hold register cleared by the grant can be reloaded by a completing word in the same cycle.
//  Output handshake: transfer on Vld & Rdy. While Vld is high and Rdy is low, Data and Ch
//   hold stable. Back-to-back transfers give one word per cycle.
//  Latency: LSB on pins at edge E -> registered E, lane hold valid E+1,
//   CpSl_TdcVld_o high E+2 when the output is idle and the lane wins arbitration.
// TESTING
//  1 Lane 0 sends 0xA5C3F1 with Frame 0xFF0000, Rdy=1 -> one Vld cycle, Data=0xA5C3F1, Ch=0, 2 clk after LSB.
//  2 All 8 lanes send 0x000100+n at once, Rdy=1 -> 8 consecutive Vld cycles, Ch 0..7 in order, no Ovf.
//  3 Rdy=0. Lane 3 sends 0x111111, then 0x222222 back-to-back, then 0x333333 -> Vld held with 0x111111.
//    Lane 3 holds 0x222222, 0x333333 is dropped, Ovf=0x08. Rdy=1 -> 0x111111 then 0x222222.
//    OvfClr -> Ovf=0.
//  4 Lane 5 Frame high for only 5 bits -> no word, FrmErr one pulse, FrmErrCnt=1. The next valid word on lane 5 is received correctly.
//  5 Reset asserted after 12 bits of a lane-2 word -> no Vld, no error. After reset release, the next lane-2 word 0x0ABCDE is output intact.
//  6 Three echoes per lane spaced 50 clk (echo1/2/3 order) -> words appear in arrival order per lane, Ch correct.

Source files
------------

// File: rtl/tdc_gpx2_frame_rx.sv
// GPX2 TDC serial result receiver: per-lane MSB-first deserialisers with frame-pattern
// check, merged onto a single valid/ready stream by a round-robin arbiter.
module tdc_gpx2_frame_rx #(
    parameter int NUM_CH   = 8,
    parameter int CH_W     = 3,
    parameter int DATA_W   = 24,
    parameter int FRAME_HI = 8
) (
    input  logic              CpSl_Clk200M_i,
    input  logic              CpSl_Rst_i,
    input  logic [NUM_CH-1:0] CpSv_Frame_i,
    input  logic [NUM_CH-1:0] CpSv_Sdo_i,
    output logic              CpSl_TdcVld_o,
    input  logic              CpSl_TdcRdy_i,
    output logic [DATA_W-1:0] CpSv_TdcData_o,
    output logic [CH_W-1:0]   CpSv_TdcCh_o,
    output logic [NUM_CH-1:0] CpSv_Ovf_o,
    input  logic              CpSl_OvfClr_i,
    output logic              CpSl_FrmErr_o,
    output logic [15:0]       CpSv_FrmErrCnt_o
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {S_IDLE, S_SHIFT} lane_state_t;

    function automatic logic [CH_W:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CH_W:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc = acc + (CH_W+1)'(v[i]);
        end
        return acc;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CH_W:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [NUM_CH-1:0] frame_p0;
    logic [NUM_CH-1:0] frame_prev_p0;
    logic [NUM_CH-1:0] sdo_p0;

    logic [NUM_CH-1:0] done_p1;
    logic [NUM_CH-1:0] err_p1;
    logic [DATA_W-1:0] word_p1 [NUM_CH];

    logic [DATA_W-1:0] hold_p1 [NUM_CH];
    logic [NUM_CH-1:0] hold_vld_p1;
    logic [NUM_CH-1:0] ovf_p1;
    logic [NUM_CH-1:0] ovf_set;

    logic              vld_p2;
    logic [DATA_W-1:0] data_p2;
    logic [CH_W-1:0]   ch_p2;
    logic [CH_W-1:0]   ptr_p2;
    logic              frmerr_p2;
    logic [15:0]       errcnt_p2;

    logic              can_load;
    logic              gnt_any;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W:0]     arb_idx;
    logic [CH_W-1:0]   ptr_nxt;

    // Stage p0: pin registers. Frame resets high so a Frame already high at release is no start.
    always_ff @(posedge CpSl_Clk200M_i) begin
        sdo_p0 <= CpSv_Sdo_i;
        if (CpSl_Rst_i) begin
            frame_p0      <= '1;
            frame_prev_p0 <= '1;
        end else begin
            frame_p0      <= CpSv_Frame_i;
            frame_prev_p0 <= frame_p0;
        end
    end

    // Stage p1: per-lane deserialiser and frame check
    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        lane_state_t       state_p1;
        lane_state_t       state_nxt;
        logic [CNT_W-1:0]  cnt_p1;
        logic [DATA_W-1:0] shift_p1;
        logic              start;
        logic              frame_ok;
        logic              last_bit;
        logic              lane_done;
        logic              lane_err;

        assign start    = frame_p0[n] & ~frame_prev_p0[n];
        assign frame_ok = frame_p0[n] == (cnt_p1 < CNT_W'(FRAME_HI));
        assign last_bit = cnt_p1 == CNT_W'(DATA_W - 1);

        always_ff @(posedge CpSl_Clk200M_i) begin
            if (CpSl_Rst_i) begin
                state_p1 <= S_IDLE;
            end else begin
                state_p1 <= state_nxt;
            end
        end

        always_comb begin
            state_nxt = state_p1;
            unique case (state_p1)
                S_IDLE:  if (start) state_nxt = S_SHIFT;
                S_SHIFT: if (!frame_ok || last_bit) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end

        always_comb begin
            lane_done = 1'b0;
            lane_err  = 1'b0;
            if (state_p1 == S_SHIFT) begin
                lane_err  = ~frame_ok;
                lane_done = frame_ok & last_bit;
            end
        end

        always_ff @(posedge CpSl_Clk200M_i) begin
            if (CpSl_Rst_i) begin
                cnt_p1   <= '0;
                shift_p1 <= '0;
            end else if (state_p1 == S_IDLE) begin
                if (start) begin
                    cnt_p1   <= CNT_W'(1);
                    shift_p1 <= DATA_W'(sdo_p0[n]);
                end
            end else begin
                cnt_p1   <= cnt_p1 + 1'b1;
                shift_p1 <= word_p1[n];
            end
        end

        // On the last bit this is the complete word; before that it is the next shift value.
        assign word_p1[n] = {shift_p1[DATA_W-2:0], sdo_p0[n]};
        assign done_p1[n] = lane_done;
        assign err_p1[n]  = lane_err;
    end

    // Round-robin search starting at the pointer; only fires when the output can take a word.
    always_comb begin
        can_load = ~vld_p2 | CpSl_TdcRdy_i;
        gnt_any  = 1'b0;
        gnt_ch   = '0;
        arb_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_idx = {1'b0, ptr_p2} + (CH_W+1)'(i);
            if (arb_idx >= (CH_W+1)'(NUM_CH)) begin
                arb_idx = arb_idx - (CH_W+1)'(NUM_CH);
            end
            if (!gnt_any && hold_vld_p1[arb_idx[CH_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_ch  = arb_idx[CH_W-1:0];
            end
        end
        gnt_vld = gnt_any & can_load;
        gnt_oh  = '0;
        if (gnt_vld) begin
            gnt_oh[gnt_ch] = 1'b1;
        end
        ptr_nxt = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
    end

    // A word completing into a hold register that is full and not being granted is lost.
    always_comb begin
        ovf_set = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ovf_set[n] = done_p1[n] & hold_vld_p1[n] & ~gnt_oh[n];
        end
    end

    always_ff @(posedge CpSl_Clk200M_i) begin
        if (CpSl_Rst_i) begin
            hold_vld_p1 <= '0;
            ovf_p1      <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                hold_p1[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (done_p1[n] && !ovf_set[n]) begin
                    hold_p1[n]     <= word_p1[n];
                    hold_vld_p1[n] <= 1'b1;
                end else if (gnt_oh[n]) begin
                    hold_vld_p1[n] <= 1'b0;
                end
            end
            ovf_p1 <= (ovf_p1 & ~{NUM_CH{CpSl_OvfClr_i}}) | ovf_set;
        end
    end

    // Stage p2: output register and error reporting
    always_ff @(posedge CpSl_Clk200M_i) begin
        if (CpSl_Rst_i) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            ch_p2   <= '0;
            ptr_p2  <= '0;
        end else if (gnt_vld) begin
            vld_p2  <= 1'b1;
            data_p2 <= hold_p1[gnt_ch];
            ch_p2   <= gnt_ch;
            ptr_p2  <= ptr_nxt;
        end else if (CpSl_TdcRdy_i) begin
            vld_p2  <= 1'b0;
        end
    end

    always_ff @(posedge CpSl_Clk200M_i) begin
        if (CpSl_Rst_i) begin
            frmerr_p2 <= 1'b0;
            errcnt_p2 <= '0;
        end else begin
            frmerr_p2 <= |err_p1;
            errcnt_p2 <= sat_add16(errcnt_p2, popcount(err_p1));
        end
    end

    assign CpSl_TdcVld_o    = vld_p2;
    assign CpSv_TdcData_o   = data_p2;
    assign CpSv_TdcCh_o     = ch_p2;
    assign CpSv_Ovf_o       = ovf_p1;
    assign CpSl_FrmErr_o    = frmerr_p2;
    assign CpSv_FrmErrCnt_o = errcnt_p2;

endmodule

// File: tb/tb_tdc_gpx2_frame_rx.sv
// Bench for tdc_gpx2_frame_rx: per-lane expected-word queues plus directed literal checks.
module tb_tdc_gpx2_frame_rx;
    localparam int NUM_CH   = 8;
    localparam int CH_W     = 3;
    localparam int DATA_W   = 24;
    localparam int FRAME_HI = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] frame_pins = '0;
    logic [NUM_CH-1:0] sdo_pins = '0;
    logic              rdy = 1'b1;
    logic              ovf_clr = 1'b0;
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
    logic [NUM_CH-1:0] ovf;
    logic              frmerr;
    logic [15:0]       errcnt;

    tdc_gpx2_frame_rx #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .FRAME_HI(FRAME_HI)
    ) dut (
        .CpSl_Clk200M_i  (clk),
        .CpSl_Rst_i      (rst),
        .CpSv_Frame_i    (frame_pins),
        .CpSv_Sdo_i      (sdo_pins),
        .CpSl_TdcVld_o   (vld),
        .CpSl_TdcRdy_i   (rdy),
        .CpSv_TdcData_o  (data),
        .CpSv_TdcCh_o    (ch),
        .CpSv_Ovf_o      (ovf),
        .CpSl_OvfClr_i   (ovf_clr),
        .CpSl_FrmErr_o   (frmerr),
        .CpSv_FrmErrCnt_o(errcnt)
    );

    always #5 clk = ~clk;

    typedef struct {logic [CH_W-1:0] ch; logic [DATA_W-1:0] data;} exp_t;
    typedef struct {int cyc; logic [CH_W-1:0] ch; logic [DATA_W-1:0] data;} xfer_t;

    exp_t  expq[$];
    xfer_t xlog[$];
    int    n_pass = 0;
    int    n_chk = 0;
    int    cyc = 0;
    int    err_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Compare process: each transfer must be the oldest outstanding word of its lane,
    // and a stalled output must keep its word.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [CH_W-1:0]   prev_ch;
    int                fidx;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (frmerr) err_pulses++;
            if (prev_stall) begin
                chk("stall_vld", 32'(vld), 32'd1);
                chk("stall_data", 32'(data), 32'(prev_data));
                chk("stall_ch", 32'(ch), 32'(prev_ch));
            end
            if (vld && rdy) begin
                fidx = -1;
                for (int i = 0; i < expq.size(); i++) begin
                    if (fidx < 0 && expq[i].ch == ch) fidx = i;
                end
                if (fidx < 0) begin
                    n_chk++;
                    $display("FAIL xfer_unexpected: got ch=%0d data=0x%0h expected no word", ch, data);
                end else begin
                    chk("xfer_data", 32'(data), 32'(expq[fidx].data));
                    expq.delete(fidx);
                end
                xlog.push_back('{cyc, ch, data});
            end
            prev_stall = vld && !rdy;
            prev_data  = data;
            prev_ch    = ch;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int lane, input logic [DATA_W-1:0] w,
                             input int nhi, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            tick();
            frame_pins[lane] = (k < nhi);
            sdo_pins[lane]   = w[DATA_W-1-k];
        end
    endtask

    task automatic expect_word(input int lane, input logic [DATA_W-1:0] w);
        expq.push_back('{CH_W'(lane), w});
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (expq.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_left", 32'(expq.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        frame_pins = '0;
        sdo_pins = '0;
        ovf_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        xlog.delete();
        err_pulses = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int lsb_cyc;
    int vld_cyc;
    logic [DATA_W-1:0] cap_data;
    logic [CH_W-1:0]   cap_ch;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ch", 32'(ch), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_frmerr", 32'(frmerr), 32'd0);
        chk("rst_errcnt", 32'(errcnt), 32'd0);

        // 1: single word, latency
        do_reset();
        rdy = 1'b1;
        expect_word(0, 24'hA5C3F1);
        send_word(0, 24'hA5C3F1, FRAME_HI, DATA_W);
        lsb_cyc = cyc;
        vld_cyc = -1;
        for (int k = 0; k < 10 && vld_cyc < 0; k++) begin
            @(negedge clk);
            if (vld) begin
                vld_cyc  = cyc;
                cap_data = data;
                cap_ch   = ch;
            end
        end
        chk("t1_latency", 32'(vld_cyc - lsb_cyc), 32'd3);
        chk("t1_data", 32'(cap_data), 32'hA5C3F1);
        chk("t1_ch", 32'(cap_ch), 32'd0);
        @(negedge clk);
        chk("t1_one_cycle", 32'(vld), 32'd0);
        drain(20);

        // 2: all lanes at once
        do_reset();
        for (int n = 0; n < NUM_CH; n++) expect_word(n, 24'h000100 + 24'(n));
        for (int n = 0; n < NUM_CH; n++) begin
            fork
                automatic int l = n;
                send_word(l, 24'h000100 + 24'(l), FRAME_HI, DATA_W);
            join_none
        end
        wait fork;
        drain(40);
        chk("t2_count", 32'(xlog.size()), 32'd8);
        if (xlog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t2_ch_order", 32'(xlog[i].ch), 32'(i));
                chk("t2_back2back", 32'(xlog[i].cyc - xlog[0].cyc), 32'(i));
            end
        end
        chk("t2_ovf", 32'(ovf), 32'd0);

        // 3: backpressure and overflow
        do_reset();
        rdy = 1'b0;
        expect_word(3, 24'h111111);
        expect_word(3, 24'h222222);
        send_word(3, 24'h111111, FRAME_HI, DATA_W);
        send_word(3, 24'h222222, FRAME_HI, DATA_W);
        send_word(3, 24'h333333, FRAME_HI, DATA_W);
        repeat (4) tick();
        @(negedge clk);
        chk("t3_vld", 32'(vld), 32'd1);
        chk("t3_data_held", 32'(data), 32'h111111);
        chk("t3_ovf", 32'(ovf), 32'h08);
        chk("t3_no_xfer", 32'(xlog.size()), 32'd0);
        rdy = 1'b1;
        drain(20);
        chk("t3_count", 32'(xlog.size()), 32'd2);
        if (xlog.size() >= 2) begin
            chk("t3_first", 32'(xlog[0].data), 32'h111111);
            chk("t3_second", 32'(xlog[1].data), 32'h222222);
        end
        chk("t3_ovf_sticky", 32'(ovf), 32'h08);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("t3_ovf_clr", 32'(ovf), 32'd0);

        // 4: short frame on lane 5
        do_reset();
        send_word(5, 24'h123456, 5, DATA_W);
        repeat (4) tick();
        chk("t4_err_pulses", 32'(err_pulses), 32'd1);
        chk("t4_errcnt", 32'(errcnt), 32'd1);
        chk("t4_no_word", 32'(xlog.size()), 32'd0);
        expect_word(5, 24'h5A5A5A);
        send_word(5, 24'h5A5A5A, FRAME_HI, DATA_W);
        drain(20);
        chk("t4_recovered", 32'(xlog.size()), 32'd1);
        chk("t4_errcnt_after", 32'(errcnt), 32'd1);

        // 5: reset mid-word on lane 2
        do_reset();
        send_word(2, 24'h0F0F0F, FRAME_HI, 12);
        tick();
        rst = 1'b1;
        frame_pins[2] = 1'b0;
        sdo_pins[2] = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        @(negedge clk);
        chk("t5_no_xfer", 32'(xlog.size()), 32'd0);
        chk("t5_vld", 32'(vld), 32'd0);
        chk("t5_no_err", 32'(err_pulses), 32'd0);
        chk("t5_errcnt", 32'(errcnt), 32'd0);
        expect_word(2, 24'h0ABCDE);
        send_word(2, 24'h0ABCDE, FRAME_HI, DATA_W);
        drain(20);
        chk("t5_count", 32'(xlog.size()), 32'd1);
        if (xlog.size() >= 1) begin
            chk("t5_data", 32'(xlog[0].data), 32'h0ABCDE);
            chk("t5_ch", 32'(xlog[0].ch), 32'd2);
        end

        // 6: three echoes per lane, 50 clk apart, lanes staggered
        do_reset();
        for (int e = 0; e < 3; e++) begin
            for (int n = 0; n < NUM_CH; n++) begin
                expect_word(n, 24'((e + 1) << 20 | n << 12 | 8'hC0 | e));
            end
        end
        for (int n = 0; n < NUM_CH; n++) begin
            fork
                automatic int l = n;
                begin
                    repeat (l * 3) tick();
                    for (int e = 0; e < 3; e++) begin
                        send_word(l, 24'((e + 1) << 20 | l << 12 | 8'hC0 | e), FRAME_HI, DATA_W);
                        repeat (50 - DATA_W) tick();
                    end
                end
            join_none
        end
        wait fork;
        drain(100);
        chk("t6_count", 32'(xlog.size()), 32'd24);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_errcnt", 32'(errcnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
